lsu_icb_sram_rsp: RTL and testbench

ICB responder (slave) terminating the LSU command channel driven by the AGU/LSU initiator, backed by a single-port synchronous SRAM with 1-cycle read latency. It accepts cmd beats, performs the SRAM read or byte-masked write, and returns in-order rsp beats through a small outstanding buffer. Out-of-range addresses get an error response. It sits between the LSU ICB master port and the data SRAM macro.

---
 rtl/lsu_icb_sram_rsp_pkg.sv | 11 +
 rtl/lsu_icb_sram_rsp_fifo.sv | 59 +++++
 rtl/lsu_icb_sram_rsp.sv | 137 +++++++++++++
 tb/tb_lsu_icb_sram_rsp.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_icb_sram_rsp_pkg.sv
// Shared constants for the LSU data-SRAM ICB responder: bus widths and the
// placement of the data SRAM in the address map.
package lsu_icb_sram_rsp_pkg;

    localparam int          XLEN           = 32;
    localparam int          ADDR_SIZE      = 32;
    localparam int          DMEM_AW        = 12;
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;
    localparam int          DMEM_OUTS      = 2;

endpackage

// File: rtl/lsu_icb_sram_rsp_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides, used to park
// responses that the initiator has not yet taken.
module icb_rsp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_reg [DEPTH];
    logic [PW:0]  wr_ptr_reg;
    logic [PW:0]  rd_ptr_reg;
    logic         push;
    logic         pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                       (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_reg[rd_ptr_reg[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg[PW-1:0] == PW'(gi))) begin
                    mem_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/lsu_icb_sram_rsp.sv
// ICB responder for the LSU data SRAM: decodes commands onto a 1-cycle
// synchronous SRAM and returns in-order responses with bounded credits.
module lsu_icb_sram_rsp
    import lsu_icb_sram_rsp_pkg::*;
#(
    parameter int              AW         = ADDR_SIZE,
    parameter int              DW         = XLEN,
    parameter int              MEM_AW     = DMEM_AW,
    parameter logic [AW-1:0]   BASE_ADDR  = AW'(DMEM_BASE_ADDR),
    parameter int              OUTS_DEPTH = DMEM_OUTS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                icb_cmd_valid,
    output logic                icb_cmd_ready,
    input  logic [AW-1:0]       icb_cmd_addr,
    input  logic                icb_cmd_read,
    input  logic [DW-1:0]       icb_cmd_wdata,
    input  logic [DW/8-1:0]     icb_cmd_wmask,
    output logic                icb_rsp_valid,
    input  logic                icb_rsp_ready,
    output logic [DW-1:0]       icb_rsp_rdata,
    output logic                icb_rsp_err,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [MEM_AW-1:0]   sram_addr,
    output logic [DW/8-1:0]     sram_wem,
    output logic [DW-1:0]       sram_din,
    input  logic [DW-1:0]       sram_dout
);

    localparam int          CW         = $clog2(OUTS_DEPTH + 1);
    localparam int          FW         = DW + 1;
    localparam logic [AW:0] RANGE_LO   = {1'b0, BASE_ADDR};
    localparam logic [AW:0] RANGE_SPAN = (AW+1)'(1) << (MEM_AW + 2);
    localparam logic [AW:0] RANGE_HI   = RANGE_LO + RANGE_SPAN;

    logic [CW-1:0]  cnt_reg;
    logic [CW-1:0]  cnt_next;
    logic           s1_vld_reg;
    logic           s1_read_reg;
    logic           s1_err_reg;
    logic [DW-1:0]  s1_rdata;
    logic           cmd_hsk;
    logic           rsp_hsk;
    logic           in_range;
    logic [AW:0]    addr_ext;

    logic           fifo_push;
    logic           fifo_in_ready;
    logic           fifo_out_valid;
    logic [FW-1:0]  fifo_out_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic [$clog2(OUTS_DEPTH):0] fifo_count;

    // Ready depends only on credits, never on icb_rsp_ready.
    assign icb_cmd_ready = rst_n & (cnt_reg < CW'(OUTS_DEPTH));
    assign cmd_hsk       = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hsk       = icb_rsp_valid & icb_rsp_ready;

    assign addr_ext = {1'b0, icb_cmd_addr};
    assign in_range = (addr_ext >= RANGE_LO) && (addr_ext < RANGE_HI);

    assign sram_cs   = cmd_hsk & in_range;
    assign sram_we   = ~icb_cmd_read;
    assign sram_addr = icb_cmd_addr[MEM_AW+1:2];
    assign sram_wem  = icb_cmd_read ? '0 : icb_cmd_wmask;
    assign sram_din  = icb_cmd_wdata;

    always_comb begin
        cnt_next = cnt_reg;
        if (cmd_hsk && !rsp_hsk) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (!cmd_hsk && rsp_hsk) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            s1_vld_reg  <= 1'b0;
            s1_read_reg <= 1'b0;
            s1_err_reg  <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            s1_vld_reg  <= cmd_hsk;
            s1_read_reg <= cmd_hsk & icb_cmd_read;
            s1_err_reg  <= cmd_hsk & ~in_range;
        end
    end

    // sram_dout is only meaningful for a good read issued last cycle.
    assign s1_rdata = (s1_read_reg && !s1_err_reg) ? sram_dout : '0;

    // s1 bypasses the FIFO only when the FIFO is empty and the rsp is taken now.
    assign fifo_push = s1_vld_reg & ~(fifo_empty & icb_rsp_ready);

    icb_rsp_fifo #(
        .W     (FW),
        .DEPTH (OUTS_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fifo_push),
        .in_ready  (fifo_in_ready),
        .in_data   ({s1_err_reg, s1_rdata}),
        .out_valid (fifo_out_valid),
        .out_ready (icb_rsp_ready),
        .out_data  (fifo_out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign icb_rsp_valid = fifo_out_valid | s1_vld_reg;

    always_comb begin
        icb_rsp_err   = s1_err_reg;
        icb_rsp_rdata = s1_rdata;
        if (fifo_out_valid) begin
            icb_rsp_err   = fifo_out_data[FW-1];
            icb_rsp_rdata = fifo_out_data[DW-1:0];
        end
    end

    // Credits bound the FIFO; any of these firing means the bookkeeping broke.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_push && !fifo_in_ready));
            assert (!fifo_full || (cnt_reg == CW'(OUTS_DEPTH)));
            assert ((CW'(fifo_count) + CW'(s1_vld_reg)) <= cnt_reg);
        end
    end

endmodule

// File: tb/tb_lsu_icb_sram_rsp.sv
// Self-checking bench for lsu_icb_sram_rsp: directed steps followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_lsu_icb_sram_rsp;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        sram_cs;
    logic        sram_we;
    logic [11:0] sram_addr;
    logic [3:0]  sram_wem;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    always #5 clk = ~clk;

    lsu_icb_sram_rsp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wem      (sram_wem),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout)
    );

    // SRAM macro stand-in: 1-cycle read latency, byte-masked write.
    logic [31:0] sram_mem [4096];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wem[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: expected memory image and queue of pending responses.
    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic [31:0] ref_mem [4096];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    bit          last_cmd_hsk;
    bit          last_rsp_hsk;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        longint unsigned v;
        v = a;
        return (v >= 64'h8000_0000) && (v < 64'h8000_0000 + 4 * 4096);
    endfunction

    // Called at the falling edge: everything seen here belongs to the current cycle.
    task automatic check_cycle();
        bit   chs;
        bit   rhs;
        bit   inr;
        int   idx;
        exp_t e;
        chk("cmd_ready", icb_cmd_ready, (rst_n === 1'b1) && (exp_q.size() < 2));
        chk("rsp_valid", icb_rsp_valid, exp_q.size() > 0);
        chs = (icb_cmd_valid === 1'b1) && (icb_cmd_ready === 1'b1);
        rhs = (icb_rsp_valid === 1'b1) && (icb_rsp_ready === 1'b1);
        inr = ref_in_range(icb_cmd_addr);
        chk("sram_cs", sram_cs, chs && inr);
        if (rhs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", icb_rsp_rdata, e.data);
            chk("rsp_err", icb_rsp_err, e.err);
            last_rdata = icb_rsp_rdata;
            last_err   = icb_rsp_err;
        end
        if (chs) begin
            idx = 0;
            if (inr) begin
                idx = int'((icb_cmd_addr - BASE) >> 2);
                chk("sram_addr", sram_addr, idx);
                chk("sram_we", sram_we, !icb_cmd_read);
                chk("sram_wem", sram_wem, icb_cmd_read ? 4'h0 : icb_cmd_wmask);
                if (!icb_cmd_read) chk("sram_din", sram_din, icb_cmd_wdata);
            end
            e.err  = !inr;
            e.data = (inr && icb_cmd_read) ? ref_mem[idx] : 32'h0;
            exp_q.push_back(e);
            if (inr && !icb_cmd_read) begin
                for (int b = 0; b < 4; b++) begin
                    if (icb_cmd_wmask[b]) ref_mem[idx][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                end
            end
        end
        last_cmd_hsk = chs;
        last_rsp_hsk = rhs;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input bit rd, input logic [31:0] wd, input logic [3:0] wm);
        int n;
        n = 0;
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = a;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        do begin
            tick();
            n++;
        end while (!last_cmd_hsk && n < 50);
        chk("issue_accept", last_cmd_hsk, 1'b1);
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        icb_rsp_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          cyc;
        int          nrsp;
        logic [31:0] bp_addr [3];
        logic [31:0] got [3];
        int          ngot;

        for (int i = 0; i < 4096; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        sram_dout     = 32'h0;
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = BASE;
        icb_cmd_read  = 1'b1;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b0;
        last_cmd_hsk  = 1'b0;
        last_rsp_hsk  = 1'b0;
        last_rdata    = 32'h0;
        last_err      = 1'b0;

        // Reset state
        tick();
        chk("rst_rdata", icb_rsp_rdata, 32'h0);
        chk("rst_err", icb_rsp_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset released: cmd_ready=%0b rsp_valid=%0b", icb_cmd_ready, icb_rsp_valid);

        // Full-word write then read back, response one cycle after the read handshake
        icb_rsp_ready = 1'b1;
        issue(32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'b1111);
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0);
        tick();
        chk("rd1_latency", last_rsp_hsk, 1'b1);
        chk("rd1_data", last_rdata, 32'hDEAD_BEEF);
        chk("rd1_err", last_err, 1'b0);
        $display("txn read 80000010 -> %h err=%0b", last_rdata, last_err);

        // Single byte lane write
        issue(32'h8000_0010, 1'b0, 32'h5A5A_5A5A, 4'b0100);
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0);
        tick();
        chk("byte_data", last_rdata, 32'hDE5A_BEEF);
        $display("txn byte-merged read 80000010 -> %h", last_rdata);

        // Zero-mask write changes nothing
        issue(32'h8000_0010, 1'b0, 32'h1234_5678, 4'b0000);
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0);
        tick();
        chk("zmask_data", last_rdata, 32'hDE5A_BEEF);

        // Address range boundaries
        issue(32'h7FFF_FFFC, 1'b1, 32'h0, 4'h0);
        tick();
        chk("below_err", last_err, 1'b1);
        chk("below_rdata", last_rdata, 32'h0);
        issue(32'h8000_4000, 1'b1, 32'h0, 4'h0);
        tick();
        chk("above_err", last_err, 1'b1);
        chk("above_rdata", last_rdata, 32'h0);
        issue(32'h8000_3FFC, 1'b1, 32'h0, 4'h0);
        tick();
        chk("top_err", last_err, 1'b0);
        $display("txn boundary reads done");
        drain();

        // Backpressure: three back-to-back reads, only two credits
        bp_addr[0] = 32'h8000_0100;
        bp_addr[1] = 32'h8000_0104;
        bp_addr[2] = 32'h8000_0108;
        for (int i = 0; i < 3; i++) issue(bp_addr[i], 1'b0, 32'h1111_1111 * (i + 1), 4'hF);
        drain();
        icb_rsp_ready = 1'b0;
        k = 0;
        ngot = 0;
        for (int c = 0; c < 6; c++) begin
            icb_cmd_valid = 1'b1;
            icb_cmd_read  = 1'b1;
            icb_cmd_addr  = bp_addr[k];
            tick();
            if (last_cmd_hsk) k++;
        end
        chk("bp_accepted", k, 2);
        icb_rsp_ready = 1'b1;
        cyc = 0;
        while ((k < 3 || exp_q.size() > 0) && cyc < 20) begin
            icb_cmd_valid = (k < 3);
            icb_cmd_addr  = bp_addr[(k < 3) ? k : 2];
            tick();
            if (last_cmd_hsk) k++;
            if (last_rsp_hsk && ngot < 3) begin
                got[ngot] = last_rdata;
                ngot++;
            end
            cyc++;
        end
        icb_cmd_valid = 1'b0;
        chk("bp_ngot", ngot, 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_order", got[i], 32'h1111_1111 * (i + 1));
            $display("txn bp rsp %0d -> %h", i, got[i]);
        end

        // 16-read burst at full throughput
        icb_rsp_ready = 1'b1;
        k = 0;
        cyc = 0;
        nrsp = 0;
        while (k < 16 && cyc < 40) begin
            icb_cmd_valid = 1'b1;
            icb_cmd_read  = 1'b1;
            icb_cmd_addr  = BASE + 32'(4 * k);
            tick();
            if (last_cmd_hsk) k++;
            if (last_rsp_hsk) nrsp++;
            cyc++;
        end
        icb_cmd_valid = 1'b0;
        tick();
        if (last_rsp_hsk) nrsp++;
        chk("burst_cycles", cyc, 16);
        chk("burst_rsps", nrsp, 16);
        $display("txn burst: %0d cmds in %0d cycles, %0d rsps", k, cyc, nrsp);
        drain();

        // Reset with two transactions in flight
        icb_rsp_ready = 1'b0;
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0);
        issue(32'h8000_0100, 1'b1, 32'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rsp_valid", icb_rsp_valid, 1'b0);
        chk("rstmid_cmd_ready", icb_cmd_ready, 1'b0);
        chk("rstmid_cs", sram_cs, 1'b0);
        chk("rstmid_rdata", icb_rsp_rdata, 32'h0);
        chk("rstmid_err", icb_rsp_err, 1'b0);
        exp_q.delete();
        icb_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        $display("txn reset mid-flight: cmd_ready=%0b rsp_valid=%0b", icb_cmd_ready, icb_rsp_valid);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (!icb_cmd_valid || last_cmd_hsk) begin
                icb_cmd_valid = ($urandom_range(0, 3) != 0);
                icb_cmd_read  = $urandom_range(0, 1);
                icb_cmd_wdata = $urandom();
                icb_cmd_wmask = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 9))
                    0:       icb_cmd_addr = BASE - 32'd4;
                    1:       icb_cmd_addr = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 3));
                    2:       icb_cmd_addr = $urandom();
                    default: icb_cmd_addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                endcase
            end
            icb_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        icb_cmd_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
